// File: rtl/fifo_pkg.sv
// Shared types and constants for the async-FIFO read/write side streamers.
// No logic.
// No flow control.
package fifo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SUM_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_streamer_stream_buf.sv
// Power-of-two circular buffer with push/pop and occupancy count.
// Latency: a pushed word is at the head on the cycle after the push when the buffer was empty.
// Backpressure: the caller must not push when full or pop when empty.
module stream_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains the async FIFO read port into a framed valid/ready stream with a per-frame checksum.
// Latency: the FIFO's one-cycle read latency plus one buffer stage, then one word per cycle.
// Backpressure: out_ready stalls are absorbed by the buffer; reads stop once the buffer plus in-flight word is full.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done,
    output logic [SUM_W-1:0]  frame_sum,
    output logic [15:0]       word_count,
    output logic              busy
);

    localparam int              OCC_W    = $clog2(BUF_DEPTH) + 1;
    localparam logic [OCC_W:0]  DEPTH_C  = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [15:0]     LAST_IDX = 16'(FRAME_LEN - 1);

    state_t             state;
    state_t             state_nxt;
    logic               inflight;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W:0]     fill;
    logic [DATA_W-1:0]  head;
    logic               hs;
    logic [15:0]        frame_idx;
    logic [SUM_W-1:0]   run_sum;
    logic [SUM_W-1:0]   word_sum;

    stream_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (hs),
        .head_data (head),
        .count     (occ)
    );

    // Count the in-flight word as occupied so a landing read always has a slot.
    assign fill       = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (fill < DEPTH_C);

    assign out_valid  = (occ != '0);
    assign out_data   = out_valid ? head : '0;
    assign out_last   = out_valid && (frame_idx == LAST_IDX);
    assign hs         = out_valid && out_ready;
    assign busy       = (state != IDLE);
    assign word_sum   = SUM_W'(out_data);

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (occ == '0 && !inflight) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame index and running sum survive IDLE so a partial frame resumes.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            inflight   <= 1'b0;
            frame_idx  <= '0;
            run_sum    <= '0;
            frame_sum  <= '0;
            word_count <= '0;
            frame_done <= 1'b0;
        end else begin
            inflight   <= fifo_rd_en;
            frame_done <= hs && out_last;
            if (hs) begin
                word_count <= word_count + 16'd1;
                if (out_last) begin
                    frame_idx <= '0;
                    frame_sum <= run_sum + word_sum;
                    run_sum   <= '0;
                end else begin
                    frame_idx <= frame_idx + 16'd1;
                    run_sum   <= run_sum + word_sum;
                end
            end
        end
    end

endmodule
